// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped cache controller.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic int byte_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int data_w,
                                 input int lines, input int words);
        return addr_w - byte_w(data_w) - off_w(words) - idx_w(lines);
    endfunction

    // Extracts 'width' bits starting at 'lsb'; callers cast to the field width.
    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int lsb, input int width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// Block data storage: one synchronous write port, one combinational read port.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int LINES  = 128,
    parameter int WORDS  = 8,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [idx_w(LINES)-1:0]   wline,
    input  logic [off_w(WORDS)-1:0]   wword,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [idx_w(LINES)-1:0]   rline,
    input  logic [off_w(WORDS)-1:0]   rword,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem [LINES*WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wline, wword}] <= wdata;
        end
    end

    assign rdata = mem[{rline, rword}];

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped write-through, write-allocate cache with in-order block fill.
// Hits complete in 0 cycles; a miss stalls WORDS+L+1 cycles while the block is fetched.
module cache_ctrl_dm
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LINES  = 128,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    localparam int BYTE_W = byte_w(DATA_W);
    localparam int OFF_W  = off_w(WORDS);
    localparam int IDX_W  = idx_w(LINES);
    localparam int TAG_W  = tag_w(ADDR_W, DATA_W, LINES, WORDS);
    localparam int CNT_W  = OFF_W + 1;

    state_t state, state_nx;

    logic [31:0]       addr32;
    logic [OFF_W-1:0]  word;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    logic [LINES-1:0]  line_vld;
    logic [TAG_W-1:0]  tag_mem [LINES];
    logic [CNT_W-1:0]  req_cnt;
    logic [CNT_W-1:0]  ret_cnt;

    logic              hit;
    logic              access;
    logic              miss;
    logic              fill_last;
    logic              req_more;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] word_addr;

    logic              arr_we;
    logic [OFF_W-1:0]  arr_word;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign addr32 = 32'(cpu_addr);
    assign word   = OFF_W'(addr_field(addr32, BYTE_W, OFF_W));
    assign idx    = IDX_W'(addr_field(addr32, BYTE_W + OFF_W, IDX_W));
    assign tag    = TAG_W'(addr_field(addr32, BYTE_W + OFF_W + IDX_W, TAG_W));

    assign hit       = line_vld[idx] && (tag_mem[idx] == tag);
    assign access    = cpu_rd | cpu_wr;
    assign miss      = access & ~hit;
    assign req_more  = (req_cnt < CNT_W'(WORDS));
    assign fill_last = (state == FILL) && mem_valid && (ret_cnt == CNT_W'(WORDS - 1));

    // The CPU holds its address during the fill, so tag/index come straight from it.
    assign fill_addr = ADDR_W'({tag, idx, req_cnt[OFF_W-1:0]}) << BYTE_W;
    assign word_addr = (cpu_addr >> BYTE_W) << BYTE_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (miss)      state_nx = FILL;
            FILL: if (fill_last) state_nx = IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = word_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = '0;
        arr_we    = 1'b0;
        arr_word  = word;
        arr_wdata = cpu_wdata;
        case (state)
            IDLE: begin
                stall = miss;
                if (cpu_rd && hit) begin
                    cpu_rdata = arr_rdata;
                end
                if (cpu_wr && hit) begin
                    mem_wr = 1'b1;
                    arr_we = 1'b1;
                end
            end
            FILL: begin
                stall = 1'b1;
                if (req_more) begin
                    mem_rd   = 1'b1;
                    mem_addr = fill_addr;
                end
                if (mem_valid) begin
                    arr_we    = 1'b1;
                    arr_word  = ret_cnt[OFF_W-1:0];
                    arr_wdata = mem_rdata;
                end
            end
        endcase
    end

    // Valid is dropped at miss time so a reset or aborted fill never exposes a partial block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt  <= '0;
            ret_cnt  <= '0;
            line_vld <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        req_cnt       <= '0;
                        ret_cnt       <= '0;
                        line_vld[idx] <= 1'b0;
                    end
                end
                FILL: begin
                    if (req_more) begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                    if (mem_valid) begin
                        ret_cnt <= ret_cnt + 1'b1;
                    end
                    if (fill_last) begin
                        line_vld[idx] <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_last) begin
            tag_mem[idx] <= tag;
        end
    end

    cache_data_array #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .DATA_W (DATA_W)
    ) u_data (
        .clk   (clk),
        .we    (arr_we),
        .wline (idx),
        .wword (arr_word),
        .wdata (arr_wdata),
        .rline (idx),
        .rword (word),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Scenario bench for cache_ctrl_dm with a 4-cycle-latency memory returning addr ^ 16'hA5A5.
module tb_cache_ctrl_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rd, cpu_wr, stall;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_valid;

    typedef struct {
        logic [15:0] addr;
        int          cyc;
        logic [15:0] dat;
    } ev_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    ev_t         pend[$];
    ev_t         exp_rd[$], obs_rd[$], exp_wr[$], obs_wr[$];
    logic [15:0] exp_dat[$];
    int          obs_stall;
    logic [15:0] obs_rdata;

    cache_ctrl_dm u_dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: request seen in cycle t is returned during cycle t+4.
    initial begin
        ev_t p;
        mem_valid = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (pend.size() > 0 && pend[0].cyc == cyc) begin
                p = pend.pop_front();
                mem_valid = 1'b1;
                mem_rdata = p.addr ^ 16'hA5A5;
            end else begin
                mem_valid = 1'b0;
            end
            @(negedge clk);
            if (mem_rd === 1'b1) pend.push_back('{mem_addr, cyc + 4, 16'h0});
        end
    end

    task automatic push_fill(input logic [15:0] a);
        for (int k = 0; k < 8; k++) exp_rd.push_back('{(a & 16'hFFF0) | 16'(2 * k), 1 + k, 16'h0});
    endtask

    // Presents one access, holds it until stall drops, and records what the DUT did.
    task automatic drive_access(input logic rd, input logic wr,
                                input logic [15:0] addr, input logic [15:0] wdata);
        int start;
        obs_rd.delete();
        obs_wr.delete();
        obs_stall = -1;
        obs_rdata = 16'hxxxx;
        @(posedge clk); #1;
        start = cyc;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_rd === 1'b1) obs_rd.push_back('{mem_addr, cyc - start, 16'h0});
            if (mem_wr === 1'b1) obs_wr.push_back('{mem_addr, cyc - start, mem_wdata});
            if (stall === 1'b0) begin
                obs_stall = cyc - start;
                obs_rdata = cpu_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (stall !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || cpu_rdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs got stall=%b mem_rd=%b mem_wr=%b rdata=%h want 0 0 0 0000",
                     stall, mem_rd, mem_wr, cpu_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cold_read;
        ev_t e, o;
        push_fill(16'h1234);
        exp_dat.push_back(16'h1234 ^ 16'hA5A5);
        drive_access(1'b1, 1'b0, 16'h1234, 16'h0);
        total++;
        if (obs_stall !== 13) begin bad++; $display("FAIL cold_stall got=%0d want=13", obs_stall); end
        total++;
        if (obs_rdata !== exp_dat[0]) begin bad++; $display("FAIL cold_rdata got=%h want=%h", obs_rdata, exp_dat[0]); end
        void'(exp_dat.pop_front());
        total++;
        if (obs_rd.size() != exp_rd.size()) begin bad++; $display("FAIL cold_rd_count got=%0d want=%0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front(); total++;
            if (o.addr !== e.addr || o.cyc !== e.cyc) begin
                bad++; $display("FAIL cold_rd_req got=%h@%0d want=%h@%0d", o.addr, o.cyc, e.addr, e.cyc);
            end
        end
        exp_rd.delete();
    endtask

    task automatic test_read_hit;
        exp_dat.push_back(16'h1236 ^ 16'hA5A5);
        drive_access(1'b1, 1'b0, 16'h1236, 16'h0);
        total++;
        if (obs_stall !== 0 || obs_rd.size() != 0) begin
            bad++; $display("FAIL hit_stall got stall=%0d reqs=%0d want 0 0", obs_stall, obs_rd.size());
        end
        total++;
        if (obs_rdata !== exp_dat[0]) begin bad++; $display("FAIL hit_rdata got=%h want=%h", obs_rdata, exp_dat[0]); end
        void'(exp_dat.pop_front());
    endtask

    task automatic test_write_hit;
        ev_t o;
        exp_wr.push_back('{16'h1238, 0, 16'hBEEF});
        drive_access(1'b0, 1'b1, 16'h1238, 16'hBEEF);
        total++;
        if (obs_stall !== 0 || obs_rd.size() != 0 || obs_wr.size() != 1) begin
            bad++; $display("FAIL whit_shape got stall=%0d reqs=%0d writes=%0d want 0 0 1", obs_stall, obs_rd.size(), obs_wr.size());
        end else begin
            o = obs_wr.pop_front(); total++;
            if (o.addr !== exp_wr[0].addr || o.dat !== exp_wr[0].dat || o.cyc !== exp_wr[0].cyc) begin
                bad++; $display("FAIL whit_mem_wr got=%h/%h@%0d want=%h/%h@%0d", o.addr, o.dat, o.cyc,
                                exp_wr[0].addr, exp_wr[0].dat, exp_wr[0].cyc);
            end
        end
        exp_wr.delete();
        exp_dat.push_back(16'hBEEF);
        drive_access(1'b1, 1'b0, 16'h1238, 16'h0);
        total++;
        if (obs_stall !== 0 || obs_rdata !== exp_dat[0]) begin
            bad++; $display("FAIL whit_readback got=%h stall=%0d want=%h stall=0", obs_rdata, obs_stall, exp_dat[0]);
        end
        void'(exp_dat.pop_front());
    endtask

    task automatic test_conflict;
        ev_t e, o;
        logic [15:0] addrs [2];
        addrs[0] = 16'h3234; addrs[1] = 16'h1234;
        for (int n = 0; n < 2; n++) begin
            push_fill(addrs[n]);
            exp_dat.push_back(addrs[n] ^ 16'hA5A5);
            drive_access(1'b1, 1'b0, addrs[n], 16'h0);
            total++;
            if (obs_stall !== 13 || obs_rdata !== exp_dat[0]) begin
                bad++; $display("FAIL conflict_%0d got stall=%0d rdata=%h want 13 %h", n, obs_stall, obs_rdata, exp_dat[0]);
            end
            void'(exp_dat.pop_front());
            total++;
            if (obs_rd.size() != exp_rd.size()) begin bad++; $display("FAIL conflict_rd_count got=%0d want=%0d", obs_rd.size(), exp_rd.size()); end
            while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
                e = exp_rd.pop_front(); o = obs_rd.pop_front(); total++;
                if (o.addr !== e.addr || o.cyc !== e.cyc) begin
                    bad++; $display("FAIL conflict_rd_req got=%h@%0d want=%h@%0d", o.addr, o.cyc, e.addr, e.cyc);
                end
            end
            exp_rd.delete();
        end
    endtask

    task automatic test_write_allocate;
        ev_t e, o;
        push_fill(16'h0100);
        exp_wr.push_back('{16'h0100, 13, 16'h0042});
        drive_access(1'b0, 1'b1, 16'h0100, 16'h0042);
        total++;
        if (obs_stall !== 13) begin bad++; $display("FAIL walloc_stall got=%0d want=13", obs_stall); end
        total++;
        if (obs_rd.size() != exp_rd.size()) begin bad++; $display("FAIL walloc_rd_count got=%0d want=%0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front(); total++;
            if (o.addr !== e.addr || o.cyc !== e.cyc) begin
                bad++; $display("FAIL walloc_rd_req got=%h@%0d want=%h@%0d", o.addr, o.cyc, e.addr, e.cyc);
            end
        end
        exp_rd.delete();
        total++;
        if (obs_wr.size() != 1) begin
            bad++; $display("FAIL walloc_wr_count got=%0d want=1", obs_wr.size());
        end else begin
            o = obs_wr.pop_front(); e = exp_wr.pop_front(); total++;
            if (o.addr !== e.addr || o.dat !== e.dat || o.cyc !== e.cyc) begin
                bad++; $display("FAIL walloc_mem_wr got=%h/%h@%0d want=%h/%h@%0d", o.addr, o.dat, o.cyc, e.addr, e.dat, e.cyc);
            end
        end
        exp_wr.delete();
        exp_dat.push_back(16'h0042);
        drive_access(1'b1, 1'b0, 16'h0100, 16'h0);
        total++;
        if (obs_stall !== 0 || obs_rdata !== exp_dat[0]) begin
            bad++; $display("FAIL walloc_readback got=%h stall=%0d want=%h stall=0", obs_rdata, obs_stall, exp_dat[0]);
        end
        void'(exp_dat.pop_front());
    endtask

    task automatic test_reset_mid_fill;
        ev_t e, o;
        int  strays = 0;
        bit  quiet  = 1'b1;
        @(posedge clk); #1;
        cpu_rd = 1'b1; cpu_addr = 16'h3234;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (mem_rd !== 1'b0) begin bad++; $display("FAIL rst_mem_rd_drop got=%b want=0", mem_rd); end
        @(negedge clk);
        if (mem_valid === 1'b1) strays++;
        rst = 1'b0; cpu_rd = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_valid === 1'b1) strays++;
            if (stall !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (strays != 4) begin bad++; $display("FAIL rst_stray_count got=%0d want=4", strays); end
        total++;
        if (!quiet) begin bad++; $display("FAIL rst_idle_quiet got=busy want=idle"); end
        push_fill(16'h1234);
        exp_dat.push_back(16'h1234 ^ 16'hA5A5);
        drive_access(1'b1, 1'b0, 16'h1234, 16'h0);
        total++;
        if (obs_stall !== 13 || obs_rdata !== exp_dat[0]) begin
            bad++; $display("FAIL rst_refill got stall=%0d rdata=%h want 13 %h", obs_stall, obs_rdata, exp_dat[0]);
        end
        void'(exp_dat.pop_front());
        total++;
        if (obs_rd.size() != exp_rd.size()) begin bad++; $display("FAIL rst_rd_count got=%0d want=%0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front(); total++;
            if (o.addr !== e.addr || o.cyc !== e.cyc) begin
                bad++; $display("FAIL rst_rd_req got=%h@%0d want=%h@%0d", o.addr, o.cyc, e.addr, e.cyc);
            end
        end
        exp_rd.delete();
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_conflict();
        test_write_allocate();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_dm.md
# cache_ctrl_dm

Parametrised direct-mapped, write-through, write-allocate cache controller with its own tag/valid/data storage and a block-fill state machine. Sits between the pipeline's fetch or memory stage and the multi-cycle main memory. Generalises the fixed 128-line, 16-byte-block cache to configurable address width, data width, line count and block size, and adds a miss FSM, a fill counter and write-through traffic.

## Interface
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width; a multiple of 8.
- LINES, 128, number of cache lines; a power of two.
- WORDS, 8, words per block; a power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_addr  in  ADDR_W  byte address of the access.
- cpu_wdata  in  DATA_W  store data.
- cpu_rd  in  1  load request.
- cpu_wr  in  1  store request; never asserted together with cpu_rd.
- cpu_rdata  out  DATA_W  load data; valid when cpu_rd=1 and stall=0.
- stall  out  1  the access is not completing; the CPU holds all cpu_* inputs stable.
- mem_addr  out  ADDR_W  memory word address, with the byte-offset bits at 0.
- mem_wdata  out  DATA_W  memory store data.
- mem_rd  out  1  one-cycle memory read request.
- mem_wr  out  1  one-cycle memory write request; always accepted.
- mem_rdata  in  DATA_W  returned read data.
- mem_valid  in  1  mem_rdata is valid. Returns come in request order, one per request.

## Operation
- Address split, LSB first: byte offset is log2(DATA_W/8) bits and ignored. Then word offset (log2 WORDS), index (log2 LINES), and tag (the remainder). Defaults give 1, 3, 7 and 5 bits.
- Hit: valid[index] is set and tag[index] equals the address tag.
- FSM states: IDLE and FILL.
- IDLE, read hit: cpu_rdata is data[index][word], combinational, with stall=0.
- IDLE, write hit: in the same cycle, data[index][word] is updated at the clock edge. mem_wr=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, and stall=0.
- IDLE, miss (rd or wr): stall=1 combinationally. Go to FILL, clear req_cnt and ret_cnt, and clear valid[index].
- FILL: stall=1. While req_cnt<WORDS, assert mem_rd with mem_addr = {tag, index, req_cnt, byte-offset 0}, then increment req_cnt.
- FILL, on each mem_valid: write mem_rdata into data[index][ret_cnt], then increment ret_cnt.
- FILL, on the mem_valid with ret_cnt==WORDS-1: set valid[index], write tag[index], and return to IDLE.
- The held access then hits in IDLE. A store completes there as a write hit, which is the write-allocate behaviour.
- mem_wr is never asserted in FILL. mem_rd is never asserted in IDLE.
- Counters are log2(WORDS)+1 bits wide. The fill always covers the whole block in ascending offset order from offset 0; there is no critical-word-first ordering.
- No access (cpu_rd=cpu_wr=0): stall=0, and no mem traffic.

## Timing
- Reset values: FSM=IDLE, all valid=0, req_cnt=ret_cnt=0, mem_rd=mem_wr=0, stall=0 (it is combinational), cpu_rdata=0 while no rd is asserted. Tag and data arrays are not reset.
- Hit latency: 0 cycles. Write-through costs no stall.
- Miss penalty with memory latency L (request at cycle t returns at t+L): the miss is presented in cycle 0. Requests go out in cycles 1..WORDS. The last return arrives in cycle WORDS+L. The hit and stall=0 occur in cycle WORDS+L+1.
- Reset asserted mid-FILL: return to IDLE immediately. All lines become invalid and mem_rd drops asynchronously. Late mem_valid pulses arriving in IDLE are ignored.
- A mem_valid arriving in IDLE is always ignored.

## Structure
- Package cache_pkg holds:
  - the state enum (IDLE, FILL);
  - functions deriving OFF_W, IDX_W and TAG_W from the parameters;
  - the address-field extraction helpers.
- One sub-module, cache_data_array: LINES×WORDS×DATA_W storage with one write port (line, word, data, we) and one combinational read port.
- Tag and valid arrays, and the FSM, live in cache_ctrl_dm.

## Test plan
All scenarios use defaults, and a memory model with L=4 that returns data = address XOR 16'hA5A5.
- Cold read of 0x1234 → stall high for 13 cycles. mem_rd pulses to 0x1230..0x123E in cycles 1–8. In cycle 13, cpu_rdata = 0x1234^0xA5A5 = 0xB791 with stall=0.
- Read of 0x1236 after that fill → stall=0 in the same cycle, cpu_rdata=0xB793, and no mem_rd.
- Store 0xBEEF to 0x1238 (a hit) → mem_wr one cycle with addr 0x1238 and data 0xBEEF, and stall=0. A following read of 0x1238 returns 0xBEEF.
- Read of 0x3234 (same index, different tag) → miss with a 13-cycle stall. A read of 0x1234 afterwards misses again.
- Store 0x0042 to cold address 0x0100 → a 13-cycle fill, then mem_wr to 0x0100 in cycle 13. A read of 0x0100 returns 0x0042.
- rst pulsed in cycle 5 of a fill → mem_rd low immediately, FSM in IDLE, and stray mem_valid pulses ignored. Re-reading 0x1234 takes the full 13-cycle miss.
